// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package restoring_divider_pkg;

   localparam int DIV_WIDTH = 16;
   localparam int CNT_WIDTH = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/restoring_divider_div_step.sv
// One restoring-division step: trial subtraction a - b through a ripple
// full-adder chain (b inverted, carry-in 1). A carry out of the top bit
// means no borrow, so the difference is kept and the quotient bit is 1;
// otherwise the shifted value is restored unchanged.
module div_step #(
   parameter int W = 17
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);

   logic [W:0]   carry;
   logic [W-1:0] diff;
   logic [W-1:0] b_n;

   assign b_n      = ~b_i;
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign diff[i]    = a_i[i] ^ b_n[i] ^ carry[i];
      assign carry[i+1] = (a_i[i] & b_n[i]) | (a_i[i] & carry[i]) | (b_n[i] & carry[i]);
   end

   assign q_o   = carry[W];
   assign rem_o = carry[W] ? diff : a_i;

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per
// clock. Results and flags are registered and held between operations.
//
// Handshake: start is sampled only in IDLE (busy=0); a start while busy is
// dropped. busy rises after the accepting edge and falls on the edge that
// raises done; done is a one-cycle pulse and results are valid from it.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNTW  = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow,
   output logic [1:0]       state_dbg
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_q;
   logic             armed_q;
   logic             busy_q, done_q, dbz_q, ovf_q;
   logic [WIDTH-1:0] quo_q, rem_out_q;
   logic [WIDTH-1:0] dvd_q, dsr_q, rem_q;
   logic [CNTW-1:0]  cnt_q;
   logic             neg_quo_q, neg_rem_q, dbz_pend_q, ovf_pend_q;
   logic [WIDTH-1:0] res_quo_q, res_rem_q;

   logic [WIDTH-1:0] dvd_mag_d, dsr_mag_d;
   logic [WIDTH:0]   shifted_d, step_rem_d;
   logic             step_q_d;
   logic             unused_step_msb;

   // Operand magnitudes; in signed mode MIN_NEG maps to 2^(WIDTH-1) unsigned.
   always_comb begin
      dvd_mag_d = dividend;
      dsr_mag_d = divisor;
      if (signed_mode && dividend[WIDTH-1]) dvd_mag_d = -dividend;
      if (signed_mode && divisor[WIDTH-1])  dsr_mag_d = -divisor;
   end

   // Partial remainder is always below the divisor, so WIDTH bits hold it;
   // the shifted trial value needs the extra bit.
   assign shifted_d       = {rem_q, dvd_q[WIDTH-1]};
   assign unused_step_msb = step_rem_d[WIDTH];

   div_step #(.W(WIDTH + 1)) u_step (
      .a_i   (shifted_d),
      .b_i   ({1'b0, dsr_q}),
      .rem_o (step_rem_d),
      .q_o   (step_q_d)
   );

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         armed_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
         quo_q      <= '0;
         rem_out_q  <= '0;
         dvd_q      <= '0;
         dsr_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dbz_pend_q <= 1'b0;
         ovf_pend_q <= 1'b0;
         res_quo_q  <= '0;
         res_rem_q  <= '0;
      end else begin
         // armed_q masks a start that coincides with reset release.
         armed_q <= 1'b1;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && armed_q) begin
                  busy_q     <= 1'b1;
                  neg_quo_q  <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_rem_q  <= signed_mode & dividend[WIDTH-1];
                  ovf_pend_q <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
                  if (divisor == '0) begin
                     res_quo_q  <= '1;
                     res_rem_q  <= dividend;
                     dbz_pend_q <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     dvd_q      <= dvd_mag_d;
                     dsr_q      <= dsr_mag_d;
                     rem_q      <= '0;
                     cnt_q      <= CNTW'(WIDTH - 1);
                     dbz_pend_q <= 1'b0;
                     state_q    <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               rem_q <= step_rem_d[WIDTH-1:0];
               dvd_q <= {dvd_q[WIDTH-2:0], step_q_d};
               if (cnt_q == '0) state_q <= ST_FIX;
               else             cnt_q   <= cnt_q - CNTW'(1);
            end
            ST_FIX: begin
               if (ovf_pend_q) begin
                  res_quo_q <= MIN_NEG;
                  res_rem_q <= '0;
               end else begin
                  res_quo_q <= neg_quo_q ? -dvd_q : dvd_q;
                  res_rem_q <= neg_rem_q ? -rem_q : rem_q;
               end
               state_q <= ST_DONE;
            end
            default: begin
               quo_q     <= res_quo_q;
               rem_out_q <= res_rem_q;
               dbz_q     <= dbz_pend_q;
               ovf_q     <= ovf_pend_q;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_out_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
   assign state_dbg   = state_q;

endmodule
